store_buffer: RTL and testbench

- Posted-write buffer that sits directly downstream of the core's data-memory port (MemWrite, DataAdr, WriteData).
- Stores are accepted in one cycle and queued in a DEPTH-entry FIFO.
- Queued stores drain in order to data memory over a valid/ready handshake.
- The core is stalled only when the buffer is full; loads that hit a pending store are flagged as hazards.

---
 rtl/sb_pkg.sv | 18 +
 rtl/store_buffer_if.sv | 30 +++
 rtl/sb_fifo.sv | 61 ++++++
 rtl/store_buffer.sv | 63 ++++++
 tb/tb_store_buffer.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/sb_pkg.sv
// Shared types and helpers for the posted-write store buffer.
package sb_pkg;

    localparam int unsigned SB_DEPTH_DEFAULT = 4;
    localparam int unsigned SB_AW            = 32;
    localparam int unsigned SB_DW            = 32;

    typedef struct packed {
        logic [SB_AW-3:0] wadr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

    // Word address of a byte address; stores are word-sized only.
    function automatic logic [SB_AW-3:0] word_adr(input logic [SB_AW-1:0] byte_adr);
        return byte_adr[SB_AW-1:2];
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core-side store/load port plus memory-side drain handshake of the store buffer.
interface store_buffer_if #(
    parameter int unsigned DEPTH = sb_pkg::SB_DEPTH_DEFAULT
) ();
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                     MemWrite;
    logic [sb_pkg::SB_AW-1:0] DataAdr;
    logic [sb_pkg::SB_DW-1:0] WriteData;
    logic                     MemRead;
    logic                     StallW;
    logic                     LoadHazard;
    logic                     mem_valid;
    logic [sb_pkg::SB_AW-1:0] mem_addr;
    logic [sb_pkg::SB_DW-1:0] mem_wdata;
    logic                     mem_ready;
    logic                     empty;
    logic [CW-1:0]            count;

    modport slave (
        input  MemWrite, DataAdr, WriteData, MemRead, mem_ready,
        output StallW, LoadHazard, mem_valid, mem_addr, mem_wdata, empty, count
    );

    modport master (
        output MemWrite, DataAdr, WriteData, MemRead, mem_ready,
        input  StallW, LoadHazard, mem_valid, mem_addr, mem_wdata, empty, count
    );

endinterface

// File: rtl/sb_fifo.sv
// In-order entry storage for the store buffer; exposes every slot's address
// and occupancy so the top can compare loads against all pending stores.
module sb_fifo
    import sb_pkg::*;
#(
    parameter  int unsigned DEPTH = SB_DEPTH_DEFAULT,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_enq,
    input  sb_entry_t                     i_entry,
    input  logic                          i_deq,
    output sb_entry_t                     o_head,
    output logic [CW-1:0]                 o_count,
    output logic [DEPTH-1:0]              o_valid,
    output logic [DEPTH-1:0][SB_AW-3:0]   o_wadr
);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    sb_entry_t     r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_enq) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (i_deq) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({i_enq, i_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            o_wadr[i]  = r_mem[i].wadr;
            o_valid[i] = {1'b0, PW'(PW'(i) - r_rd_ptr)} < r_count;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and data memory: single-cycle
// store accept, in-order drain, stall only when full, load-after-store hazard flag.
module store_buffer
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  sb
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                        w_enq;
    logic                        w_deq;
    logic                        w_valid;
    logic                        w_full;
    logic                        w_hit;
    sb_entry_t                   w_in;
    sb_entry_t                   w_head;
    logic [CW-1:0]               w_count;
    logic [DEPTH-1:0]            w_vmask;
    logic [DEPTH-1:0][SB_AW-3:0] w_wadr;

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_enq   (w_enq),
        .i_entry (w_in),
        .i_deq   (w_deq),
        .o_head  (w_head),
        .o_count (w_count),
        .o_valid (w_vmask),
        .o_wadr  (w_wadr)
    );

    // A full buffer still takes a store when the head leaves in the same cycle.
    assign w_valid = (w_count != '0);
    assign w_full  = (w_count == CW'(DEPTH));
    assign w_deq   = w_valid & sb.mem_ready;
    assign w_enq   = sb.MemWrite & (~w_full | w_deq);
    assign w_in    = {word_adr(sb.DataAdr), sb.WriteData};

    // Incoming store is deliberately excluded; the draining head is included.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (w_vmask[i] && (w_wadr[i] == word_adr(sb.DataAdr))) begin
                w_hit = 1'b1;
            end
        end
    end

    assign sb.StallW     = sb.MemWrite & ~w_enq;
    assign sb.LoadHazard = sb.MemRead & w_hit;
    assign sb.mem_valid  = w_valid;
    assign sb.mem_addr   = w_valid ? {w_head.wadr, 2'b00} : '0;
    assign sb.mem_wdata  = w_valid ? w_head.data : '0;
    assign sb.empty      = ~w_valid;
    assign sb.count      = w_count;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_store_buffer;
    import sb_pkg::*;

    localparam int unsigned DEPTH = SB_DEPTH_DEFAULT;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(DEPTH)) sb ();
    store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .sb(sb));

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
    } ref_t;

    ref_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                         input logic mr, input logic rdy);
        sb.MemWrite  = mw;
        sb.DataAdr   = adr;
        sb.WriteData = wd;
        sb.MemRead   = mr;
        sb.mem_ready = rdy;
    endtask

    // One clock: drive after the edge, check against the model, then advance the model.
    task automatic step(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                        input logic mr, input logic rdy, output logic stalled);
        bit ev, deq, enq, hit;
        @(posedge clk);
        #1 drive(mw, adr, wd, mr, rdy);
        #1;
        ev  = (q.size() != 0);
        deq = ev && rdy;
        enq = mw && ((q.size() < DEPTH) || deq);
        hit = 0;
        foreach (q[i]) if (q[i].adr[31:2] == adr[31:2]) hit = 1;
        chk("count", 64'(sb.count), 64'(q.size()));
        chk("empty", 64'(sb.empty), 64'(!ev));
        chk("mem_valid", 64'(sb.mem_valid), 64'(ev));
        if (ev) begin
            chk("mem_addr", 64'(sb.mem_addr), 64'({q[0].adr[31:2], 2'b00}));
            chk("mem_wdata", 64'(sb.mem_wdata), 64'(q[0].data));
        end
        chk("StallW", 64'(sb.StallW), 64'(mw && !enq));
        chk("LoadHazard", 64'(sb.LoadHazard), 64'(mr && hit));
        if (deq) void'(q.pop_front());
        if (enq) q.push_back('{adr, wd});
        stalled = mw && !enq;
    endtask

    task automatic cyc(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                       input logic mr, input logic rdy);
        logic s;
        step(mw, adr, wd, mr, rdy, s);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(sb.mem_valid), 64'(0));
        chk({tag, "_count"}, 64'(sb.count), 64'(0));
        chk({tag, "_empty"}, 64'(sb.empty), 64'(1));
        chk({tag, "_addr"}, 64'(sb.mem_addr), 64'(0));
        chk({tag, "_wdata"}, 64'(sb.mem_wdata), 64'(0));
        chk({tag, "_stall"}, 64'(sb.StallW), 64'(0));
        chk({tag, "_hazard"}, 64'(sb.LoadHazard), 64'(0));
    endtask

    initial begin
        logic        pend, stalled, mr, rdy;
        logic [31:0] p_adr, p_wd, adr;

        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1 check_reset_outputs("por");
        #11 reset = 1'b1;

        // Single store then drain
        cyc(1'b1, 32'd252, 32'd22, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

        // Fill to full with memory stalled, fifth store held until the head drains
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 1'b0, 1'b0);
        cyc(1'b1, 32'h110, 32'hA4, 1'b0, 1'b1);

        // Drain with ready toggling
        begin
            logic [5:0] pat;
            pat = 6'b101101;
            for (int i = 5; i >= 0; i--) cyc(1'b0, 32'd0, 32'd0, 1'b0, pat[i]);
        end

        // Load hazard against a pending store
        cyc(1'b1, 32'h64, 32'd7, 1'b0, 1'b0);
        cyc(1'b0, 32'h66, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'h68, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'h64, 32'd0, 1'b1, 1'b1);
        cyc(1'b0, 32'h64, 32'd0, 1'b1, 1'b0);

        // Steady simultaneous enqueue/dequeue at occupancy 2
        cyc(1'b1, 32'h300, 32'h11, 1'b0, 1'b0);
        cyc(1'b1, 32'h304, 32'h22, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 32'h400 + 32'(i * 4), $urandom, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

        // Asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h500 + 32'(i * 4), 32'hBEEF0 + 32'(i), 1'b0, 1'b0);
        #2 reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1 check_reset_outputs("mid_rst");
        q.delete();
        #3 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h500, 32'd0, 1'b1, 1'b1);
            chk("post_rst_addr", 64'(sb.mem_addr), 64'(0));
        end

        // Randomized traffic; a stalled store is re-presented unchanged
        pend  = 1'b0;
        p_adr = '0;
        p_wd  = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pend && ($urandom_range(0, 1) == 1)) begin
                pend  = 1'b1;
                p_adr = 32'h200 + 32'($urandom_range(0, 31));
                p_wd  = $urandom;
            end
            mr  = !pend && ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            adr = pend ? p_adr : 32'h200 + 32'($urandom_range(0, 31));
            step(pend, adr, p_wd, mr, rdy, stalled);
            if (!stalled) pend = 1'b0;
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
